// File: rtl/exe_stage_pipe.sv
// Registered ARM execute stage: Val2 generation, ALU with NZCV, branch target, EXE/MEM register.
// Define MUL_EN to include the iterative radix-2 shift-add multiplier for exe_cmd 1010.
module exe_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 24,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              stall,
    input  logic              flush,
    input  logic [3:0]        exe_cmd,
    input  logic              s_in,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              imm,
    input  logic [11:0]       shift_operand,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [IMM_W-1:0]  imm_signed,
    input  logic [3:0]        sr,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    output logic              wb_en,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] br_addr,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest,
    output logic [3:0]        status,
    output logic              status_wr,
    output logic              busy
);
    localparam int MSB = DATA_W - 1;
    localparam logic [3:0] OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010, OP_ADC = 4'b0011,
                           OP_SUB = 4'b0100, OP_SBC = 4'b0101, OP_AND = 4'b0110, OP_ORR = 4'b0111,
                           OP_EOR = 4'b1000;

    // Handshake: an instruction transfers on a rising edge where in_valid && in_ready; in_ready
    // drops while the multiplier iterates or downstream stalls, and out_valid marks a live result.
    logic accept, is_mul;
    assign in_ready = !busy && !stall;
    assign accept   = in_valid && in_ready;

    logic [31:0]       imm32, imm_rot;
    logic [5:0]        rot2;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] val2;
    always_comb begin
        imm32   = {24'b0, shift_operand[7:0]};
        rot2    = {shift_operand[11:8], 1'b0};
        imm_rot = (imm32 >> rot2) | (imm32 << (6'd32 - rot2));
        shamt   = shift_operand[11:7];
        if (mem_r_en_in || mem_w_en_in)
            val2 = DATA_W'(shift_operand);
        else if (imm)
            val2 = DATA_W'(imm_rot);
        else begin
            case (shift_operand[6:5])
                2'b00:   val2 = val_rm << shamt;
                2'b01:   val2 = val_rm >> shamt;
                2'b10:   val2 = $unsigned($signed(val_rm) >>> shamt);
                default: val2 = (val_rm >> shamt) | (val_rm << (DATA_W - int'(shamt)));
            endcase
        end
    end

    logic [DATA_W:0]   wide;
    logic [DATA_W-1:0] alu_res;
    logic [3:0]        flags;
    logic              flags_wr;
    always_comb begin
        wide     = '0;
        alu_res  = '0;
        flags    = sr;
        flags_wr = 1'b0;
        case (exe_cmd)
            OP_MOV: begin alu_res = val2;  flags_wr = 1'b1; end
            OP_MVN: begin alu_res = ~val2; flags_wr = 1'b1; end
            OP_ADD, OP_ADC: begin
                wide     = {1'b0, val_rn} + {1'b0, val2}
                         + {{DATA_W{1'b0}}, (exe_cmd == OP_ADC) & sr[1]};
                alu_res  = wide[MSB:0];
                flags[1] = wide[DATA_W];
                flags[0] = (val_rn[MSB] == val2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
                flags_wr = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                // Bit DATA_W of the widened difference is the borrow; ARM C is its inverse.
                wide     = {1'b0, val_rn} - {1'b0, val2}
                         - {{DATA_W{1'b0}}, (exe_cmd == OP_SBC) & ~sr[1]};
                alu_res  = wide[MSB:0];
                flags[1] = ~wide[DATA_W];
                flags[0] = (val_rn[MSB] != val2[MSB]) && (alu_res[MSB] != val_rn[MSB]);
                flags_wr = 1'b1;
            end
            OP_AND: begin alu_res = val_rn & val2; flags_wr = 1'b1; end
            OP_ORR: begin alu_res = val_rn | val2; flags_wr = 1'b1; end
            OP_EOR: begin alu_res = val_rn ^ val2; flags_wr = 1'b1; end
            default: ;
        endcase
        if (flags_wr) begin
            flags[3] = alu_res[MSB];
            flags[2] = (alu_res == '0);
        end
    end

    logic [DATA_W-1:0] br_calc;
    assign br_calc = pc_in + (DATA_W'($signed(imm_signed)) << 2);

`ifdef MUL_EN
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam int CNT_W = $clog2(DATA_W + 1);
    logic [CNT_W-1:0]  mul_cnt;
    logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier, mul_rm, mul_br;
    logic [DEST_W-1:0] mul_dest;
    logic              mul_wb, mul_mr, mul_mw, mul_s, busy_r, mul_done;
    logic [1:0]        mul_cv;
    assign is_mul   = (exe_cmd == OP_MUL);
    assign busy     = busy_r;
    assign mul_done = busy_r && (mul_cnt == CNT_W'(DATA_W));

    // DATA_W iterations follow the accept edge; the product then sits in mul_acc until unstalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0; mul_cnt <= '0; mul_acc <= '0; mul_mcand <= '0; mul_mplier <= '0;
            mul_rm <= '0; mul_br <= '0; mul_dest <= '0; mul_cv <= '0;
            mul_wb <= 1'b0; mul_mr <= 1'b0; mul_mw <= 1'b0; mul_s <= 1'b0;
        end else if (flush) begin
            busy_r  <= 1'b0;
            mul_cnt <= '0;
        end else if (accept && is_mul) begin
            busy_r <= 1'b1; mul_cnt <= '0; mul_acc <= '0;
            mul_mcand <= val_rn; mul_mplier <= val_rm;
            mul_rm <= val_rm; mul_br <= br_calc; mul_dest <= dest_in; mul_cv <= sr[1:0];
            mul_wb <= wb_en_in; mul_mr <= mem_r_en_in; mul_mw <= mem_w_en_in; mul_s <= s_in;
        end else if (busy_r && !mul_done) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end else if (mul_done && !stall) begin
            busy_r  <= 1'b0;
            mul_cnt <= '0;
        end
    end
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0; wb_en <= 1'b0; mem_r_en <= 1'b0; mem_w_en <= 1'b0;
            alu_result <= '0; br_addr <= '0; val_rm_out <= '0; dest <= '0;
            status <= '0; status_wr <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0; wb_en <= 1'b0; mem_r_en <= 1'b0; mem_w_en <= 1'b0;
            status_wr <= 1'b0;
        end else if (stall) begin
            out_valid <= out_valid;
`ifdef MUL_EN
        end else if (mul_done) begin
            out_valid <= 1'b1; wb_en <= mul_wb; mem_r_en <= mul_mr; mem_w_en <= mul_mw;
            alu_result <= mul_acc; br_addr <= mul_br; val_rm_out <= mul_rm; dest <= mul_dest;
            status_wr <= mul_s;
            if (mul_s) status <= {mul_acc[MSB], mul_acc == '0, mul_cv};
`endif
        end else if (accept && !is_mul) begin
            out_valid <= 1'b1; wb_en <= wb_en_in; mem_r_en <= mem_r_en_in; mem_w_en <= mem_w_en_in;
            alu_result <= alu_res; br_addr <= br_calc; val_rm_out <= val_rm; dest <= dest_in;
            status_wr <= s_in && flags_wr;
            if (s_in && flags_wr) status <= flags;
        end else begin
            out_valid <= 1'b0; wb_en <= 1'b0; mem_r_en <= 1'b0; mem_w_en <= 1'b0;
            status_wr <= 1'b0;
        end
    end
endmodule
